// File: rtl/risc_pkg.sv
// Shared encodings for the ALU issue/retire sequencer: opcodes, func codes,
// ALU control codes, sequencer states and the decoded-instruction bundle.
package risc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_COMPI = 6'd2;
    localparam logic [5:0] OP_BR    = 6'd3;
    localparam logic [5:0] OP_BLTZ  = 6'd4;
    localparam logic [5:0] OP_BZ    = 6'd5;
    localparam logic [5:0] OP_BNZ   = 6'd6;
    localparam logic [5:0] OP_B     = 6'd7;
    localparam logic [5:0] OP_BCY   = 6'd8;
    localparam logic [5:0] OP_BNCY  = 6'd9;

    localparam logic [4:0] FN_ADD   = 5'd0;
    localparam logic [4:0] FN_COMP  = 5'd1;
    localparam logic [4:0] FN_AND   = 5'd2;
    localparam logic [4:0] FN_XOR   = 5'd3;
    localparam logic [4:0] FN_SHLL  = 5'd4;
    localparam logic [4:0] FN_SHRL  = 5'd5;
    localparam logic [4:0] FN_SHLLV = 5'd6;
    localparam logic [4:0] FN_SHRLV = 5'd7;
    localparam logic [4:0] FN_SHRA  = 5'd8;
    localparam logic [4:0] FN_SHRAV = 5'd9;

    // Bit positions inside the {V, C, S, Z} flag register
    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [3:0] {
        ALU_XOR   = 4'd0,
        ALU_AND   = 4'd1,
        ALU_ADD   = 4'd2,
        ALU_COMP  = 4'd3,
        ALU_SHIFT = 4'd4,
        ALU_BRREG = 4'd5
    } aluCtrl_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        RETIRE = 2'd2
    } seqState_e;

    typedef enum logic {
        SEL_A_ZERO = 1'b0,
        SEL_A_RS   = 1'b1
    } aSel_e;

    typedef enum logic [2:0] {
        SEL_B_ZERO  = 3'd0,
        SEL_B_RT    = 3'd1,
        SEL_B_IMM   = 3'd2,
        SEL_B_SHAMT = 3'd3,
        SEL_B_RTAMT = 3'd4
    } bSel_e;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_REG    = 3'd1,
        BR_LTZ    = 3'd2,
        BR_ZERO   = 3'd3,
        BR_NZERO  = 3'd4,
        BR_ALWAYS = 3'd5,
        BR_CY     = 3'd6,
        BR_NCY    = 3'd7
    } brKind_e;

    typedef struct packed {
        aluCtrl_e aluCtrl;
        logic     shiftDir;
        logic     shiftOp;
        aSel_e    aSel;
        bSel_e    bSel;
        logic     flagEn;
        logic     wbEn;
        brKind_e  brKind;
        logic     illegal;
    } decode_t;

    function automatic logic [31:0] signExt16(input logic [15:0] val);
        return {{16{val[15]}}, val};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of a latched instruction word into ALU controls,
// operand selects, flag-update enable, branch kind and illegal indication.
module instr_decoder
    import risc_pkg::*;
(
    input  logic [31:0] instr,
    output decode_t     dec
);

    logic [5:0] opcode;
    logic [4:0] func;

    assign opcode = instr[31:26];
    assign func   = instr[4:0];

    always_comb begin
        dec.aluCtrl  = ALU_XOR;
        dec.shiftDir = 1'b0;
        dec.shiftOp  = 1'b0;
        dec.aSel     = SEL_A_ZERO;
        dec.bSel     = SEL_B_ZERO;
        dec.flagEn   = 1'b0;
        dec.wbEn     = 1'b0;
        dec.brKind   = BR_NONE;
        dec.illegal  = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                dec.wbEn = 1'b1;
                dec.aSel = SEL_A_RS;
                case (func)
                    FN_ADD: begin
                        dec.aluCtrl = ALU_ADD;
                        dec.bSel    = SEL_B_RT;
                        dec.flagEn  = 1'b1;
                    end
                    FN_COMP: begin
                        dec.aluCtrl = ALU_COMP;
                        dec.aSel    = SEL_A_ZERO;
                        dec.bSel    = SEL_B_RT;
                        dec.flagEn  = 1'b1;
                    end
                    FN_AND: begin
                        dec.aluCtrl = ALU_AND;
                        dec.bSel    = SEL_B_RT;
                        dec.flagEn  = 1'b1;
                    end
                    FN_XOR: begin
                        dec.aluCtrl = ALU_XOR;
                        dec.bSel    = SEL_B_RT;
                        dec.flagEn  = 1'b1;
                    end
                    FN_SHLL, FN_SHRL, FN_SHRA: begin
                        dec.aluCtrl = ALU_SHIFT;
                        dec.bSel    = SEL_B_SHAMT;
                    end
                    FN_SHLLV, FN_SHRLV, FN_SHRAV: begin
                        dec.aluCtrl = ALU_SHIFT;
                        dec.bSel    = SEL_B_RTAMT;
                    end
                    default: begin
                        dec.wbEn    = 1'b0;
                        dec.aSel    = SEL_A_ZERO;
                        dec.illegal = 1'b1;
                    end
                endcase
                dec.shiftDir = (func == FN_SHRL) || (func == FN_SHRLV) ||
                               (func == FN_SHRA) || (func == FN_SHRAV);
                dec.shiftOp  = (func == FN_SHRA) || (func == FN_SHRAV);
            end

            OP_ADDI: begin
                dec.aluCtrl = ALU_ADD;
                dec.aSel    = SEL_A_RS;
                dec.bSel    = SEL_B_IMM;
                dec.flagEn  = 1'b1;
                dec.wbEn    = 1'b1;
            end

            OP_COMPI: begin
                dec.aluCtrl = ALU_COMP;
                dec.bSel    = SEL_B_IMM;
                dec.flagEn  = 1'b1;
                dec.wbEn    = 1'b1;
            end

            OP_BR, OP_BLTZ, OP_BZ, OP_BNZ, OP_B, OP_BCY, OP_BNCY: begin
                // rs passes through the ALU so sign/zero come back as flags
                dec.aluCtrl = ALU_BRREG;
                dec.aSel    = SEL_A_RS;
                case (opcode)
                    OP_BR:   dec.brKind = BR_REG;
                    OP_BLTZ: dec.brKind = BR_LTZ;
                    OP_BZ:   dec.brKind = BR_ZERO;
                    OP_BNZ:  dec.brKind = BR_NZERO;
                    OP_B:    dec.brKind = BR_ALWAYS;
                    OP_BCY:  dec.brKind = BR_CY;
                    OP_BNCY: dec.brKind = BR_NCY;
                    default: dec.brKind = BR_NONE;
                endcase
            end

            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Three-state issue/retire controller in front of the 32-bit ALU: accept,
// execute on the ALU, then retire as write-back, branch or illegal pulse.
module alu_sequencer
    import risc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    output logic              shift_dir,
    output logic              shift_op,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_zero,
    input  logic              alu_sign,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic [3:0]        flags,
    output logic              illegal
);

    seqState_e         state;
    logic [31:0]       instrR;
    logic [DATA_W-1:0] rsDataR;
    logic [DATA_W-1:0] rtDataR;
    decode_t           dec;
    logic              accept;
    logic              brCond;
    logic [DATA_W-1:0] immExt;
    logic [DATA_W-1:0] brTgt;

    assign accept = in_valid && in_ready && (state == IDLE);
    assign immExt = signExt16(instrR[15:0]);

    instr_decoder uDecoder (
        .instr (instrR),
        .dec   (dec)
    );

    // Operand registers carry no reset: they are only observed in EXEC
    always_ff @(posedge clk) begin
        if (accept) begin
            instrR  <= instr;
            rsDataR <= rs_data;
            rtDataR <= rt_data;
        end
    end

    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = 4'd0;
        shift_dir = 1'b0;
        shift_op  = 1'b0;
        if (state == EXEC) begin
            alu_ctrl  = dec.aluCtrl;
            shift_dir = dec.shiftDir;
            shift_op  = dec.shiftOp;
            if (dec.aSel == SEL_A_RS) begin
                alu_a = rsDataR;
            end
            case (dec.bSel)
                SEL_B_RT:    alu_b = rtDataR;
                SEL_B_IMM:   alu_b = immExt;
                SEL_B_SHAMT: alu_b = {{(DATA_W-5){1'b0}}, instrR[10:6]};
                SEL_B_RTAMT: alu_b = {{(DATA_W-5){1'b0}}, rtDataR[4:0]};
                default:     alu_b = '0;
            endcase
        end
    end

    // Carry branches read the flag register, so a preceding ADD/COMP is visible
    always_comb begin
        case (dec.brKind)
            BR_REG, BR_ALWAYS: brCond = 1'b1;
            BR_LTZ:            brCond = alu_sign;
            BR_ZERO:           brCond = alu_zero;
            BR_NZERO:          brCond = !alu_zero;
            BR_CY:             brCond = flags[FLAG_C];
            BR_NCY:            brCond = !flags[FLAG_C];
            default:           brCond = 1'b0;
        endcase
        brTgt = (dec.brKind == BR_REG) ? rsDataR : immExt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            br_taken  <= 1'b0;
            br_target <= '0;
            illegal   <= 1'b0;
            flags     <= 4'b0;
        end else begin
            case (state)
                IDLE: begin
                    wb_valid <= 1'b0;
                    br_taken <= 1'b0;
                    illegal  <= 1'b0;
                    if (accept) begin
                        in_ready <= 1'b0;
                        state    <= EXEC;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end

                EXEC: begin
                    wb_valid <= dec.wbEn;
                    br_taken <= brCond;
                    illegal  <= dec.illegal;
                    if (dec.wbEn) begin
                        wb_addr <= instrR[25:21];
                        wb_data <= alu_res;
                    end
                    if (brCond) begin
                        br_target <= brTgt;
                    end
                    if (dec.flagEn) begin
                        flags <= {alu_ovf, alu_carry, alu_sign, alu_zero};
                    end
                    state <= RETIRE;
                end

                RETIRE: begin
                    wb_valid <= 1'b0;
                    br_taken <= 1'b0;
                    illegal  <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end

                default: begin
                    in_ready <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU attached to the ALU ports, directed
// cases followed by randomized instructions checked against a reference model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_ctrl;
    logic        shift_dir, shift_op;
    logic        alu_zero, alu_sign, alu_carry, alu_ovf;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        br_taken;
    logic [31:0] br_target;
    logic [3:0]  flags;
    logic        illegal;

    int          errCnt = 0;
    int          chkCnt = 0;
    logic [3:0]  flagModel = 4'b0;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .shift_dir(shift_dir), .shift_op(shift_op),
        .alu_res(alu_res), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .br_taken(br_taken), .br_target(br_target), .flags(flags),
        .illegal(illegal)
    );

    // Behavioural ALU: returns {V, C, S, Z, result}
    function automatic logic [35:0] aluModel(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b, input logic dir,
                                             input logic sop);
        logic [32:0] sum;
        logic [31:0] r;
        logic        cy, ov;
        r = '0; cy = 1'b0; ov = 1'b0; sum = '0;
        case (c)
            4'd0: r = a ^ b;
            4'd1: r = a & b;
            4'd2: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[31:0];
                cy  = sum[32];
                ov  = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd3: begin
                r  = ~b + 32'd1;
                cy = (b == 32'd0);
                ov = (b == 32'h8000_0000);
            end
            4'd4: r = dir ? (sop ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0])) : (a << b[4:0]);
            4'd5: r = a;
            default: r = '0;
        endcase
        return {ov, cy, r[31], (r == 32'd0), r};
    endfunction

    assign {alu_ovf, alu_carry, alu_sign, alu_zero, alu_res} =
        aluModel(alu_ctrl, alu_a, alu_b, shift_dir, shift_op);

    typedef struct {
        logic        wb;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        br;
        logic [31:0] tgt;
        logic        ill;
        logic [3:0]  fl;
        logic        chkOps;
        logic        chkBrReg;
        logic [3:0]  ctrl;
        logic        dir;
        logic        sop;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    // Reference: what retiring this instruction must produce, from the ISA rules
    function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] rs,
                                     input logic [31:0] rt, input logic [3:0] fin);
        exp_t        e;
        logic [5:0]  op;
        logic [4:0]  fn, amt;
        logic [31:0] simm, a, b;
        logic [3:0]  code;
        logic        arith, isShift;
        e = '{default: 0};
        op = ins[31:26];
        fn = ins[4:0];
        simm = {{16{ins[15]}}, ins[15:0]};
        e.fl = fin;
        e.addr = ins[25:21];
        arith = 1'b0; isShift = 1'b0; amt = '0; a = '0; b = '0; code = '0;
        case (op)
            6'd0: begin
                case (fn)
                    5'd0: begin arith = 1'b1; code = 4'd2; a = rs; b = rt; end
                    5'd1: begin arith = 1'b1; code = 4'd3; a = 32'd0; b = rt; end
                    5'd2: begin arith = 1'b1; code = 4'd1; a = rs; b = rt; end
                    5'd3: begin arith = 1'b1; code = 4'd0; a = rs; b = rt; end
                    5'd4: begin isShift = 1'b1; amt = ins[10:6]; end
                    5'd5: begin isShift = 1'b1; amt = ins[10:6]; e.dir = 1'b1; end
                    5'd8: begin isShift = 1'b1; amt = ins[10:6]; e.dir = 1'b1; e.sop = 1'b1; end
                    5'd6: begin isShift = 1'b1; amt = rt[4:0]; end
                    5'd7: begin isShift = 1'b1; amt = rt[4:0]; e.dir = 1'b1; end
                    5'd9: begin isShift = 1'b1; amt = rt[4:0]; e.dir = 1'b1; e.sop = 1'b1; end
                    default: e.ill = 1'b1;
                endcase
            end
            6'd1: begin arith = 1'b1; code = 4'd2; a = rs; b = simm; end
            6'd2: begin arith = 1'b1; code = 4'd3; a = 32'd0; b = simm; end
            6'd3: begin e.br = 1'b1; e.tgt = rs; end
            6'd4: begin e.br = rs[31]; e.tgt = simm; e.chkBrReg = 1'b1; end
            6'd5: begin e.br = (rs == 32'd0); e.tgt = simm; e.chkBrReg = 1'b1; end
            6'd6: begin e.br = (rs != 32'd0); e.tgt = simm; e.chkBrReg = 1'b1; end
            6'd7: begin e.br = 1'b1; e.tgt = simm; end
            6'd8: begin e.br = fin[2]; e.tgt = simm; end
            6'd9: begin e.br = !fin[2]; e.tgt = simm; end
            default: e.ill = 1'b1;
        endcase
        if (arith) begin
            {e.fl, e.data} = aluModel(code, a, b, 1'b0, 1'b0);
            e.wb = 1'b1; e.chkOps = 1'b1; e.ctrl = code; e.a = a; e.b = b;
        end
        if (isShift) begin
            if (!e.dir)
                e.data = rs << amt;
            else if (!e.sop)
                e.data = rs >> amt;
            else
                e.data = (rs >> amt) | (rs[31] ? ~(32'hFFFF_FFFF >> amt) : 32'h0);
            e.wb = 1'b1; e.chkOps = 1'b1; e.ctrl = 4'd4; e.a = rs; e.b = {27'b0, amt};
        end
        return e;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] sh, input logic [4:0] fn);
        return {6'd0, rs, rt, 5'd0, sh, 1'b0, fn};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [15:0] imm);
        return {op, rs, 5'd0, imm};
    endfunction

    // Issues one instruction and checks EXEC, RETIRE and the cycle after
    task automatic doInstr(input string tag, input logic [31:0] ins,
                           input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkVal({tag, ".ready"}, 32'(in_ready), 32'd1);
        e = predict(ins, rs, rt, flagModel);
        in_valid = 1'b1; instr = ins; rs_data = rs; rt_data = rt;
        @(posedge clk); #1;
        instr = $urandom; rs_data = $urandom; rt_data = $urandom;
        @(negedge clk);
        checkVal({tag, ".busy"}, 32'(in_ready), 32'd0);
        if (e.chkOps) begin
            checkVal({tag, ".ctrl"}, 32'(alu_ctrl), 32'(e.ctrl));
            checkVal({tag, ".dir"}, 32'(shift_dir), 32'(e.dir));
            checkVal({tag, ".sop"}, 32'(shift_op), 32'(e.sop));
            checkVal({tag, ".alu_a"}, alu_a, e.a);
            checkVal({tag, ".alu_b"}, alu_b, e.b);
        end
        if (e.chkBrReg) begin
            checkVal({tag, ".brctrl"}, 32'(alu_ctrl), 32'd5);
            checkVal({tag, ".bra"}, alu_a, rs);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkVal({tag, ".wb_valid"}, 32'(wb_valid), 32'(e.wb));
        checkVal({tag, ".br_taken"}, 32'(br_taken), 32'(e.br));
        checkVal({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
        checkVal({tag, ".flags"}, 32'(flags), 32'(e.fl));
        if (e.wb) begin
            checkVal({tag, ".wb_addr"}, 32'(wb_addr), 32'(e.addr));
            checkVal({tag, ".wb_data"}, wb_data, e.data);
        end
        if (e.br) checkVal({tag, ".br_target"}, br_target, e.tgt);
        checkVal({tag, ".alu_idle"}, alu_a | alu_b | 32'(alu_ctrl), 32'd0);
        flagModel = e.fl;
        @(negedge clk);
        checkVal({tag, ".ready_back"}, 32'(in_ready), 32'd1);
        checkVal({tag, ".strobes_off"}, {29'd0, wb_valid, br_taken, illegal}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errCnt);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        sawWb;
        logic [31:0] ins, rs, rt;
        logic [5:0]  op;
        int          sel;

        repeat (3) @(negedge clk);
        checkVal("reset.ready", 32'(in_ready), 32'd0);
        checkVal("reset.outs", {26'd0, wb_valid, br_taken, illegal, shift_dir, shift_op, 1'b0}, 32'd0);
        checkVal("reset.flags", 32'(flags), 32'd0);
        checkVal("reset.alu", alu_a | alu_b | 32'(alu_ctrl), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("reset.ready_release", 32'(in_ready), 32'd1);

        doInstr("add", encR(5'd3, 5'd4, 5'd0, 5'd0), 32'h7FFF_FFFF, 32'd1);
        checkVal("add.flags_lit", 32'(flags), 32'b1010);
        doInstr("shra", encR(5'd6, 5'd0, 5'd4, 5'd8), 32'hF000_0000, 32'd0);
        checkVal("shra.flags_held", 32'(flags), 32'b1010);
        doInstr("bz_taken", encI(6'd5, 5'd1, 16'hFFF0), 32'd0, 32'd0);
        doInstr("bz_not", encI(6'd5, 5'd1, 16'hFFF0), 32'd5, 32'd0);
        doInstr("addi", encI(6'd1, 5'd2, 16'h0001), 32'hFFFF_FFFF, 32'd0);
        checkVal("addi.flags_lit", 32'(flags), 32'b0101);
        doInstr("bcy", encI(6'd8, 5'd0, 16'h0040), 32'd0, 32'd0);
        doInstr("bncy", encI(6'd9, 5'd0, 16'h0040), 32'd0, 32'd0);
        doInstr("illegal", {6'h3F, 26'h155_5555}, 32'd7, 32'd9);

        // Reset asserted while an ADD is in EXEC
        in_valid = 1'b1; instr = encR(5'd3, 5'd4, 5'd0, 5'd0);
        rs_data = 32'h0000_0010; rt_data = 32'h0000_0020;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkVal("rst.exec_ctrl", 32'(alu_ctrl), 32'd2);
        rst_n = 1'b0;
        #1;
        sawWb = wb_valid;
        checkVal("rst.flags_cleared", 32'(flags), 32'd0);
        checkVal("rst.alu_cleared", alu_a | alu_b | 32'(alu_ctrl), 32'd0);
        repeat (2) begin
            @(negedge clk);
            sawWb = sawWb | wb_valid;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            sawWb = sawWb | wb_valid | br_taken | illegal;
        end
        checkVal("rst.no_strobe", 32'(sawWb), 32'd0);
        checkVal("rst.ready", 32'(in_ready), 32'd1);
        checkVal("rst.flags", 32'(flags), 32'd0);
        flagModel = 4'b0;
        doInstr("post_rst_add", encR(5'd9, 5'd0, 5'd0, 5'd0), 32'd100, 32'd23);

        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 10)      op = 6'(sel);
            else if (sel < 12) op = 6'($urandom_range(10, 63));
            else               op = 6'd0;
            ins = $urandom;
            ins[31:26] = op;
            if (op == 6'd0) ins[4:0] = 5'($urandom_range(0, 11));
            case ($urandom_range(0, 3))
                0:       rs = 32'd0;
                1:       rs = 32'h8000_0000 | 32'($urandom_range(0, 255));
                default: rs = $urandom;
            endcase
            rt = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
            doInstr("rnd", ins, rs, rt);
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
